// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared types and constants for the USB TX packetizer
package usb_pkg;

    // Packet phases, in transmit order.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_PID    = 3'd2,
        ST_DATA   = 3'd3,
        ST_CRC_LO = 3'd4,
        ST_CRC_HI = 3'd5,
        ST_DRAIN  = 3'd6
    } usb_tx_state_e;

    // SYNC pattern 0000_0001 sent LSB-first appears as 8'h80 on the byte bus.
    localparam logic [7:0]  SYNC_BYTE    = 8'h80;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_R = 16'hA001;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    // The PID byte carries its own check nibble in the upper half.
    function automatic logic [7:0] pid_byte(input logic [3:0] p);
        return {~p, p};
    endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// rtl/usb_crc16_byte.sv - combinational one-byte step of the USB CRC16
//
// Ports:
//   crc_in  [15:0]  running CRC before this byte
//   byte_in [7:0]   byte to fold in, bit 0 first on the wire
//   crc_out [15:0]  running CRC after this byte
module usb_crc16_byte
    import usb_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);

    logic [15:0] acc;

    // Reflected form: the whole byte is folded into the low end up front,
    // then eight shift-right steps apply the reversed polynomial.
    always_comb begin
        acc = crc_in ^ {8'h00, byte_in};
        for (int i = 0; i < 8; i++) begin
            if (acc[0]) begin
                acc = (acc >> 1) ^ CRC16_POLY_R;
            end else begin
                acc = acc >> 1;
            end
        end
        crc_out = acc;
    end

endmodule

// File: rtl/usb_tx_packetizer.sv
// rtl/usb_tx_packetizer.sv - builds SYNC/PID/payload/CRC16 byte stream for the TX serializer
//
// Ports:
//   clk          system clock
//   n_rst        asynchronous active-low reset
//   start        1-cycle request to send a packet (ignored while busy)
//   pid [3:0]    PID nibble, sent as {~pid, pid}
//   handshake    with start: send SYNC+PID only
//   byte_count   with start: payload length, clamped to MAX_BYTES
//   fifo_rdata   TX FIFO head byte (show-ahead)
//   fifo_empty   TX FIFO empty
//   fifo_read    pop of the FIFO head, same cycle as the consuming load
//   load_enable  serializer has taken the byte on data
//   data [7:0]   byte presented to the serializer
//   sending      packet in flight, including shift-out of the last byte
//   busy         FSM not idle
//   done         1-cycle pulse, packet fully shifted out
//   underrun     1-cycle pulse, FIFO empty when a payload byte was needed
module usb_tx_packetizer
    import usb_pkg::*;
#(
    parameter  int MAX_BYTES = 64,
    localparam int CW        = $clog2(MAX_BYTES + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic [3:0]    pid,
    input  logic          handshake,
    input  logic [CW-1:0] byte_count,
    input  logic [7:0]    fifo_rdata,
    input  logic          fifo_empty,
    output logic          fifo_read,
    input  logic          load_enable,
    output logic [7:0]    data,
    output logic          sending,
    output logic          busy,
    output logic          done,
    output logic          underrun
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_SYNC   = ST_SYNC;
    localparam logic [2:0] S_PID    = ST_PID;
    localparam logic [2:0] S_DATA   = ST_DATA;
    localparam logic [2:0] S_CRC_LO = ST_CRC_LO;
    localparam logic [2:0] S_CRC_HI = ST_CRC_HI;
    localparam logic [2:0] S_DRAIN  = ST_DRAIN;

    logic [2:0]    state;
    logic [3:0]    pid_lat;
    logic          hs_lat;
    logic [CW-1:0] bc_lat;
    logic [CW-1:0] count;
    logic [15:0]   crc;
    logic [15:0]   crc_next;
    logic [CW-1:0] bc_clamped;

    assign bc_clamped = (byte_count > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : byte_count;
    assign busy       = (state != S_IDLE);

    // Pop is combinational so the FIFO advances on the same edge the byte
    // is consumed; an empty FIFO is never popped (that cycle is an underrun).
    assign fifo_read  = (state == S_DATA) && load_enable && !fifo_empty;

    // CRC covers the byte the serializer just took, i.e. what is on data.
    usb_crc16_byte u_crc (
        .crc_in  (crc),
        .byte_in (data),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= S_IDLE;
            data     <= 8'h00;
            sending  <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
            pid_lat  <= 4'h0;
            hs_lat   <= 1'b0;
            bc_lat   <= '0;
            count    <= '0;
            crc      <= CRC16_INIT;
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    // load_enable is meaningless here and deliberately ignored.
                    if (start) begin
                        pid_lat <= pid;
                        hs_lat  <= handshake;
                        bc_lat  <= bc_clamped;
                        count   <= '0;
                        crc     <= CRC16_INIT;
                        data    <= SYNC_BYTE;
                        sending <= 1'b1;
                        state   <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (load_enable) begin
                        data  <= pid_byte(pid_lat);
                        state <= S_PID;
                    end
                end
                S_PID: begin
                    if (load_enable) begin
                        if (hs_lat) begin
                            state <= S_DRAIN;
                        end else if (bc_lat == '0) begin
                            data  <= ~crc[7:0];
                            state <= S_CRC_LO;
                        end else begin
                            data  <= fifo_rdata;
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (load_enable) begin
                        if (fifo_empty) begin
                            underrun <= 1'b1;
                            sending  <= 1'b0;
                            data     <= 8'h00;
                            state    <= S_IDLE;
                        end else begin
                            crc   <= crc_next;
                            count <= count + CW'(1);
                            if (count == bc_lat - CW'(1)) begin
                                data  <= ~crc_next[7:0];
                                state <= S_CRC_LO;
                            end else begin
                                data <= fifo_rdata;
                            end
                        end
                    end else begin
                        // Keep tracking the head: it changes one cycle after a
                        // pop, and may arrive late if the FIFO was empty.
                        data <= fifo_rdata;
                    end
                end
                S_CRC_LO: begin
                    if (load_enable) begin
                        data  <= ~crc[15:8];
                        state <= S_CRC_HI;
                    end
                end
                S_CRC_HI: begin
                    if (load_enable) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The next load strobe means the last byte has left the
                    // shift register, so the packet is now on the wire.
                    if (load_enable) begin
                        sending <= 1'b0;
                        done    <= 1'b1;
                        data    <= 8'h00;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    sending <= 1'b0;
                    data    <= 8'h00;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// tb/tb_usb_tx_packetizer.sv - self-checking bench for usb_tx_packetizer
module tb_usb_tx_packetizer;
    import usb_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start;
    logic [3:0] pid;
    logic       handshake;
    logic [6:0] byte_count;
    logic [7:0] fifo_rdata;
    logic       fifo_empty;
    logic       fifo_read;
    logic       load_enable;
    logic [7:0] data;
    logic       sending;
    logic       busy;
    logic       done;
    logic       underrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    usb_tx_packetizer #(.MAX_BYTES(64)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .pid         (pid),
        .handshake   (handshake),
        .byte_count  (byte_count),
        .fifo_rdata  (fifo_rdata),
        .fifo_empty  (fifo_empty),
        .fifo_read   (fifo_read),
        .load_enable (load_enable),
        .data        (data),
        .sending     (sending),
        .busy        (busy),
        .done        (done),
        .underrun    (underrun)
    );

    // Show-ahead FIFO owned by the bench.
    logic [7:0] fifo_mem [0:255];
    logic [7:0] rd_ptr = 8'd0;
    logic [7:0] wr_ptr = 8'd0;
    logic       fifo_flush = 1'b0;
    assign fifo_rdata = fifo_mem[rd_ptr];
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_flush)     rd_ptr <= wr_ptr;
        else if (fifo_read) rd_ptr <= rd_ptr + 8'd1;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected wire stream: bytes in order, flagged when they come from the FIFO.
    typedef struct {
        logic [7:0] b;
        bit         pay;
    } ent_t;
    ent_t exp_q[$];
    ent_t e;
    bit   in_pkt   = 0;
    bit   done_exp = 0;
    bit   und_exp  = 0;
    int   pops     = 0;

    // Bitwise reference CRC: one wire bit at a time, LSB first.
    function automatic logic [15:0] crc_bits(input logic [7:0] bs[$], input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ bs[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    task automatic ex(input logic [7:0] b, input bit pay);
        ent_t t;
        t.b   = b;
        t.pay = pay;
        exp_q.push_back(t);
    endtask

    task automatic expect_pkt(input logic [3:0] p, input bit hs, input int n, input logic [7:0] bs[$]);
        logic [15:0] c;
        exp_q.delete();
        ex(8'h80, 0);
        ex({~p, p}, 0);
        if (!hs) begin
            for (int i = 0; i < n; i++) ex(bs[i], 1);
            c = ~crc_bits(bs, n);
            ex(c[7:0], 0);
            ex(c[15:8], 0);
        end
    endtask

    // Compare process: every cycle, mid-period.
    always @(negedge clk) begin
        if (!n_rst) begin
            chk("rst_data", 16'(data), 16'h0000);
            chk("rst_sending", 16'(sending), 16'd0);
            chk("rst_busy", 16'(busy), 16'd0);
            chk("rst_done", 16'(done), 16'd0);
            chk("rst_underrun", 16'(underrun), 16'd0);
            chk("rst_fifo_read", 16'(fifo_read), 16'd0);
            in_pkt   = 0;
            done_exp = 0;
            und_exp  = 0;
            exp_q.delete();
        end else begin
            if (fifo_read) pops++;
            chk("sending", 16'(sending), 16'(in_pkt));
            chk("busy", 16'(busy), 16'(in_pkt));
            chk("done", 16'(done), 16'(done_exp));
            chk("underrun", 16'(underrun), 16'(und_exp));
            done_exp = 0;
            und_exp  = 0;
            if (in_pkt && load_enable) begin
                if (exp_q.size() == 0) begin
                    chk("drain_fifo_read", 16'(fifo_read), 16'd0);
                    done_exp = 1;
                    in_pkt   = 0;
                end else begin
                    e = exp_q.pop_front();
                    if (e.pay && fifo_empty) begin
                        chk("underrun_fifo_read", 16'(fifo_read), 16'd0);
                        und_exp = 1;
                        in_pkt  = 0;
                        exp_q.delete();
                    end else begin
                        chk("data", 16'(data), 16'(e.b));
                        chk("fifo_read", 16'(fifo_read), 16'(e.pay));
                    end
                end
            end else begin
                chk("idle_fifo_read", 16'(fifo_read), 16'd0);
                if (!in_pkt && start) in_pkt = 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_fifo(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic flush_fifo();
        fifo_flush = 1'b1;
        tick(1);
        fifo_flush = 1'b0;
    endtask

    // Start a packet, then strobe load_enable once every 8+ clocks until idle.
    task automatic run_pkt(input logic [3:0] p, input bit hs, input logic [6:0] bc,
                           input int jit, input int poke, input bit le_start, output int nl);
        pid         = p;
        handshake   = hs;
        byte_count  = bc;
        start       = 1'b1;
        load_enable = le_start;
        tick(1);
        start       = 1'b0;
        load_enable = 1'b0;
        nl = 0;
        while (busy && nl < 100) begin
            tick(6 + ((jit > 0) ? int'($urandom_range(0, jit)) : 0));
            if (nl == poke) begin
                start      = 1'b1;
                pid        = PID_ACK;
                handshake  = 1'b1;
                byte_count = 7'd0;
            end
            tick(1);
            start       = 1'b0;
            load_enable = 1'b1;
            tick(1);
            load_enable = 1'b0;
            nl++;
        end
        chk("pkt_finished", 16'(busy), 16'd0);
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        int nl;
        int p0;

        n_rst = 1'b0; start = 1'b0; pid = 4'h0; handshake = 1'b0;
        byte_count = 7'd0; load_enable = 1'b0;
        tick(3);
        n_rst = 1'b1;
        tick(2);

        // Pin the reference CRC to the standard CRC-16/USB check value.
        q.delete();
        for (int i = 1; i <= 9; i++) q.push_back(8'(8'h30 + i));
        chk("model_crc_check", ~crc_bits(q, 9), 16'hB4C8);

        // 1: ACK handshake
        exp_q.delete(); ex(8'h80, 0); ex(8'hD2, 0);
        p0 = pops;
        run_pkt(PID_ACK, 1'b1, 7'd5, 0, -1, 1'b0, nl);
        chk("t1_loads", 16'(nl), 16'd3);
        chk("t1_pops", 16'(pops - p0), 16'd0);

        // 2: DATA0 zero-length, load_enable coincident with start is ignored
        exp_q.delete(); ex(8'h80, 0); ex(8'hC3, 0); ex(8'h00, 0); ex(8'h00, 0);
        run_pkt(PID_DATA0, 1'b0, 7'd0, 0, -1, 1'b1, nl);
        chk("t2_loads", 16'(nl), 16'd5);

        // 3: DATA1 with 00 01 02 03
        q.delete();
        for (int i = 0; i < 4; i++) begin q.push_back(8'(i)); push_fifo(8'(i)); end
        expect_pkt(PID_DATA1, 1'b0, 4, q);
        chk("t3_pid_byte", 16'(exp_q[1].b), 16'h004B);
        p0 = pops;
        run_pkt(PID_DATA1, 1'b0, 7'd4, 0, -1, 1'b0, nl);
        chk("t3_loads", 16'(nl), 16'd9);
        chk("t3_pops", 16'(pops - p0), 16'd4);

        // 4: underrun on third payload byte
        q.delete(); q.push_back(8'hA0); q.push_back(8'hA1); q.push_back(8'h00);
        push_fifo(8'hA0); push_fifo(8'hA1);
        expect_pkt(PID_DATA0, 1'b0, 3, q);
        p0 = pops;
        run_pkt(PID_DATA0, 1'b0, 7'd3, 0, -1, 1'b0, nl);
        chk("t4_loads", 16'(nl), 16'd5);
        chk("t4_pops", 16'(pops - p0), 16'd2);
        chk("t4_busy", 16'(busy), 16'd0);

        // 5a: start pulsed mid-packet is ignored
        q.delete();
        for (int i = 0; i < 3; i++) begin q.push_back(8'(8'h5A + i)); push_fifo(8'(8'h5A + i)); end
        expect_pkt(PID_DATA1, 1'b0, 3, q);
        run_pkt(PID_DATA1, 1'b0, 7'd3, 0, 3, 1'b0, nl);
        chk("t5_loads", 16'(nl), 16'd8);

        // 5b: async reset during DATA
        q.delete();
        for (int i = 0; i < 4; i++) begin q.push_back(8'(8'hC0 + i)); push_fifo(8'(8'hC0 + i)); end
        expect_pkt(PID_DATA1, 1'b0, 4, q);
        p0 = pops;
        pid = PID_DATA1; handshake = 1'b0; byte_count = 7'd4;
        start = 1'b1; tick(1); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(7); load_enable = 1'b1; tick(1); load_enable = 1'b0;
        end
        tick(2);
        #2 n_rst = 1'b0;
        #1;
        chk("async_data", 16'(data), 16'h0000);
        chk("async_sending", 16'(sending), 16'd0);
        chk("async_busy", 16'(busy), 16'd0);
        chk("async_fifo_read", 16'(fifo_read), 16'd0);
        load_enable = 1'b1;
        tick(3);
        load_enable = 1'b0;
        chk("t5_pops_frozen", 16'(pops - p0), 16'd1);
        n_rst = 1'b1;
        flush_fifo();
        tick(2);
        q.delete();
        for (int i = 0; i < 4; i++) begin q.push_back(8'(8'h10 * i + 8'h7)); push_fifo(8'(8'h10 * i + 8'h7)); end
        expect_pkt(PID_DATA0, 1'b0, 4, q);
        p0 = pops;
        run_pkt(PID_DATA0, 1'b0, 7'd4, 0, -1, 1'b0, nl);
        chk("t5_restart_loads", 16'(nl), 16'd9);
        chk("t5_restart_pops", 16'(pops - p0), 16'd4);

        // 6: 64-byte payload with random stalls
        q.delete();
        for (int i = 0; i < 64; i++) begin q.push_back(8'($urandom)); push_fifo(q[i]); end
        expect_pkt(PID_DATA1, 1'b0, 64, q);
        p0 = pops;
        run_pkt(PID_DATA1, 1'b0, 7'd64, 5, -1, 1'b0, nl);
        chk("t6_loads", 16'(nl), 16'd69);
        chk("t6_pops", 16'(pops - p0), 16'd64);

        // 7: byte_count above the maximum is clamped to 64
        q.delete();
        for (int i = 0; i < 64; i++) begin q.push_back(8'(8'hFF - i)); push_fifo(q[i]); end
        expect_pkt(PID_DATA0, 1'b0, 64, q);
        p0 = pops;
        run_pkt(PID_DATA0, 1'b0, 7'd100, 0, -1, 1'b0, nl);
        chk("t7_loads", 16'(nl), 16'd69);
        chk("t7_pops", 16'(pops - p0), 16'd64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
